// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divider.
// Operation encoding matches the EX-stage decode of DIV.W/DIV.WU/MOD.W/MOD.WU.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_W  = 2'b00,
        DIV_WU = 2'b01,
        MOD_W  = 2'b10,
        MOD_WU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV_W) || (op == MOD_W);
    endfunction

    function automatic logic op_is_mod(input div_op_t op);
        return (op == MOD_W) || (op == MOD_WU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
// The remainder is one bit wider than the operands so the shifted value never overflows.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_rem_shift;
    logic [XLEN:0] w_divisor_ext;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    assign w_rem_shift   = {i_rem[XLEN-1:0], i_quo[XLEN-1]};
    assign w_divisor_ext = {1'b0, i_divisor};
    assign w_diff        = w_rem_shift - w_divisor_ext;
    assign w_fits        = (w_rem_shift >= w_divisor_ext);

    assign o_rem = w_fits ? w_diff : w_rem_shift;
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for EX: freezes the pipeline via stall_div while iterating,
// then presents a registered quotient/remainder in DONE until MEM can capture it.
module div_unit
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_div_en,
    input  logic [1:0]      EX_div_op,
    input  logic [XLEN-1:0] EX_div_src1,
    input  logic [XLEN-1:0] EX_div_src2,
    input  logic            stall_dcache,
    input  logic            WB_flush_csr,
    output logic            stall_div,
    output logic [XLEN-1:0] EX_div_result,
    output logic            EX_div_done
);

    div_state_t      r_state;
    div_state_t      w_next_state;
    div_op_t         r_op;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic            r_q_neg;
    logic            r_r_neg;
    logic [XLEN-1:0] r_result;

    div_op_t         w_op;
    logic            w_signed;
    logic            w_start;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN:0]   w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_q_final;
    logic [XLEN-1:0] w_r_final;

    assign w_op     = div_op_t'(EX_div_op);
    assign w_signed = op_is_signed(w_op);
    // abs(0x8000_0000) wraps to itself, which is the correct unsigned magnitude.
    assign w_abs1   = (w_signed && EX_div_src1[XLEN-1]) ? -EX_div_src1 : EX_div_src1;
    assign w_abs2   = (w_signed && EX_div_src2[XLEN-1]) ? -EX_div_src2 : EX_div_src2;

    div_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    assign w_q_final = r_q_neg ? -w_quo_next : w_quo_next;
    assign w_r_final = r_r_neg ? -w_rem_next[XLEN-1:0] : w_rem_next[XLEN-1:0];

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        stall_div    = 1'b0;
        EX_div_done  = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (EX_div_en && !WB_flush_csr) begin
                    stall_div    = 1'b1;
                    w_start      = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (WB_flush_csr) begin
                    w_next_state = IDLE;
                end else begin
                    stall_div = 1'b1;
                    if (r_cnt == '0) w_next_state = DONE;
                end
            end
            DONE: begin
                // EX_div_en here is still the finished instruction, so it never restarts.
                if (WB_flush_csr) begin
                    w_next_state = IDLE;
                end else begin
                    EX_div_done = 1'b1;
                    if (!stall_dcache) w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: datapath registers are reset too, so the result bus is 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= DIV_W;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_result  <= '0;
        end else if (w_start) begin
            r_op      <= w_op;
            r_divisor <= w_abs2;
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_cnt     <= CNT_W'(XLEN - 1);
            r_q_neg   <= w_signed & (EX_div_src1[XLEN-1] ^ EX_div_src2[XLEN-1]);
            r_r_neg   <= w_signed & EX_div_src1[XLEN-1];
        end else if (r_state == BUSY && !WB_flush_csr) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_result <= op_is_mod(r_op) ? w_r_final : w_q_final;
        end
    end

    assign EX_div_result = r_result;

endmodule
